// File: rtl/mant_skid_buf_if.sv
// Valid/ready handshake bundle for the mantissa skid buffer.
// Carries the upstream and downstream sides plus the occupancy status.
interface mant_skid_buf_if #(
    parameter int WIDTH = 24,
    parameter int NCH   = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [1:0]           occupancy;

    // The buffer itself: it consumes upstream beats and produces downstream beats.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    // The environment around the buffer: the producer and the consumer.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/mant_skid_buf.sv
// Two-entry elastic register stage carrying NCH packed operand mantissas.
// Handshake outputs come straight from flops, so upstream never sees a combinational ready.
module mant_skid_buf #(
    parameter int WIDTH = 24,
    parameter int NCH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    mant_skid_buf_if.slave bus
);
    localparam int DW = WIDTH * NCH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    state_t          nxt_state;
    logic [DW-1:0]   main_q;
    logic [DW-1:0]   skid_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [1:0]      occ_q;
    logic            accept;
    logic            take;

    assign accept = bus.in_valid & in_ready_q;
    assign take   = out_valid_q & bus.out_ready;

    // State encoding doubles as the entry count, so occupancy mirrors the next state.
    always_comb begin
        nxt_state = state;
        if (flush) begin
            nxt_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) nxt_state = ONE;
                ONE: begin
                    if (accept && !take)      nxt_state = FULL;
                    else if (!accept && take) nxt_state = EMPTY;
                end
                FULL:    if (take) nxt_state = ONE;
                default: nxt_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state       <= nxt_state;
            in_ready_q  <= (nxt_state != FULL);
            out_valid_q <= (nxt_state != EMPTY);
            occ_q       <= nxt_state;
            // A flush empties the buffer logically but leaves the data registers untouched.
            if (!flush) begin
                case (state)
                    EMPTY: if (accept) main_q <= bus.in_data;
                    ONE: begin
                        if (accept && take) main_q <= bus.in_data;
                        else if (accept)    skid_q <= bus.in_data;
                    end
                    FULL:    if (take) main_q <= skid_q;
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_mant_skid_buf.sv
// Bench for mant_skid_buf: directed vector table for the listed scenarios,
// then randomized handshakes scored against a queue-based model of the buffer.
module tb_mant_skid_buf;
    localparam int WIDTH = 24;
    localparam int NCH   = 2;
    localparam int DW    = WIDTH * NCH;

    logic clk;
    logic rst;
    logic flush;

    mant_skid_buf_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    mant_skid_buf #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          r;
        logic          f;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic [1:0]    occ;
        logic          ov;
        logic          ir;
        logic          chkD;
        logic [DW-1:0] od;
    } vec_t;

    vec_t          tbl[$];
    logic [DW-1:0] modelQ[$];
    int            errors = 0;
    int            checks = 0;

    function automatic logic [DW-1:0] pk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {b, a};
    endfunction

    function automatic logic [DW-1:0] beat(input int n);
        return pk(24'(n), 24'hA00000 + 24'(n));
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [DW-1:0] d,
                                input logic ordy, input logic [1:0] occ, input logic ov, input logic ir,
                                input logic chkD, input logic [DW-1:0] od);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.occ = occ; v.ov = ov; v.ir = ir; v.chkD = chkD; v.od = od;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle at the falling edge.
    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [DW-1:0] d, input logic ordy);
        bit mAcc;
        bit mTake;
        rst           = r;
        flush         = f;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        mAcc  = iv && (modelQ.size() < 2);
        mTake = ordy && (modelQ.size() > 0);
        @(posedge clk);
        if (r || f) begin
            modelQ.delete();
        end else begin
            if (mTake) void'(modelQ.pop_front());
            if (mAcc)  modelQ.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] eOcc, input logic eOv,
                               input logic eIr, input logic eChkD, input logic [DW-1:0] eOd);
        cmp({tag, ".occupancy"}, DW'(bus.occupancy), DW'(eOcc));
        cmp({tag, ".out_valid"}, DW'(bus.out_valid), DW'(eOv));
        cmp({tag, ".in_ready"},  DW'(bus.in_ready),  DW'(eIr));
        if (eChkD) cmp({tag, ".out_data"}, bus.out_data, eOd);
    endtask

    initial begin
        logic [DW-1:0] p1, p2, p3, rd;
        logic          rv, ro, rf;
        int            sz;

        p1 = pk(24'h800001, 24'hC00000);
        p2 = pk(24'hFFFFFF, 24'h800000);
        p3 = pk(24'h912345, 24'hABCDEF);

        //           r  f  iv d         ordy occ ov ir chkD od
        tbl.push_back(mk(1, 0, 1, p1,       0, 0, 0, 1, 1, '0));
        tbl.push_back(mk(1, 0, 1, p1,       0, 0, 0, 1, 1, '0));
        tbl.push_back(mk(0, 0, 1, p1,       1, 1, 1, 1, 1, p1));
        tbl.push_back(mk(0, 0, 1, p2,       1, 1, 1, 1, 1, p2));
        tbl.push_back(mk(0, 0, 1, p3,       1, 1, 1, 1, 1, p3));
        tbl.push_back(mk(0, 0, 0, '0,       1, 0, 0, 1, 0, '0));
        tbl.push_back(mk(0, 0, 1, beat(1),  1, 1, 1, 1, 1, beat(1)));
        tbl.push_back(mk(0, 0, 1, beat(2),  0, 2, 1, 0, 1, beat(1)));
        tbl.push_back(mk(0, 0, 1, beat(3),  0, 2, 1, 0, 1, beat(1)));
        tbl.push_back(mk(0, 0, 1, beat(3),  0, 2, 1, 0, 1, beat(1)));
        tbl.push_back(mk(0, 0, 1, beat(3),  1, 1, 1, 1, 1, beat(2)));
        tbl.push_back(mk(0, 0, 1, beat(3),  1, 1, 1, 1, 1, beat(3)));
        tbl.push_back(mk(0, 0, 1, beat(4),  1, 1, 1, 1, 1, beat(4)));
        tbl.push_back(mk(0, 0, 0, '0,       1, 0, 0, 1, 0, '0));
        tbl.push_back(mk(0, 0, 1, beat(5),  0, 1, 1, 1, 1, beat(5)));
        tbl.push_back(mk(0, 0, 1, beat(6),  0, 2, 1, 0, 1, beat(5)));
        tbl.push_back(mk(0, 0, 0, '0,       1, 1, 1, 1, 1, beat(6)));
        tbl.push_back(mk(0, 0, 0, '0,       1, 0, 0, 1, 0, '0));
        tbl.push_back(mk(0, 0, 1, beat(5),  0, 1, 1, 1, 1, beat(5)));
        tbl.push_back(mk(0, 0, 1, beat(6),  0, 2, 1, 0, 1, beat(5)));
        tbl.push_back(mk(0, 1, 1, beat(7),  0, 0, 0, 1, 0, '0));
        tbl.push_back(mk(0, 0, 1, beat(8),  0, 1, 1, 1, 1, beat(8)));
        tbl.push_back(mk(0, 0, 0, '0,       1, 0, 0, 1, 0, '0));
        tbl.push_back(mk(0, 0, 1, beat(9),  0, 1, 1, 1, 1, beat(9)));
        tbl.push_back(mk(0, 1, 1, beat(10), 1, 0, 0, 1, 0, '0));
        tbl.push_back(mk(0, 0, 0, '0,       0, 0, 0, 1, 0, '0));
        tbl.push_back(mk(0, 0, 1, beat(11), 0, 1, 1, 1, 1, beat(11)));
        tbl.push_back(mk(0, 0, 0, '0,       1, 0, 0, 1, 0, '0));

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            checkOutput($sformatf("vec%0d", i), tbl[i].occ, tbl[i].ov, tbl[i].ir, tbl[i].chkD, tbl[i].od);
        end

        applyStimulus(1, 0, 0, '0, 0);
        checkOutput("rand_reset", 2'd0, 1'b0, 1'b1, 1'b1, '0);

        for (int i = 0; i < 10000; i++) begin
            rv = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            rf = ($urandom_range(0, 199) == 0);
            rd = {16'($urandom()), 32'($urandom())};
            applyStimulus(1'b0, rf, rv, rd, ro);
            sz = modelQ.size();
            checkOutput($sformatf("rand%0d", i), 2'(sz), sz > 0, sz < 2, sz > 0,
                        (sz > 0) ? modelQ[0] : '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mant_skid_buf.md
# mant_skid_buf

Parametrised elastic register stage for the floating-point multiplier datapath. It carries NCH operand mantissas of WIDTH bits each, e.g. mantissa A and mantissa B, between pipeline stages. It replaces the fixed, always-load operand register with a valid/ready handshake and a 2-entry skid buffer. Upstream sees a registered ready, downstream may stall without losing data, and full throughput (one transfer per cycle) is sustained when not stalled.

## Interface
- WIDTH, 24, bits per operand channel (23-bit fraction + hidden bit).
- NCH, 2, number of operand channels carried in lockstep.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream presents a beat.
- in_ready  output  1  block can accept a beat; driven directly from state register.
- in_data  input  NCH*WIDTH  packed operands; channel k at bits [k*WIDTH +: WIDTH], channel 0 = A.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream takes the beat.
- out_data  output  NCH*WIDTH  packed operands, same channel packing as in_data.
- occupancy  output  2  number of entries held (0, 1 or 2).

## Operation
- Storage: main register (drives out_data) and skid register, each NCH*WIDTH bits.
- Accept = in_valid & in_ready.
- Take = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
- in_ready = (state != FULL).
- out_valid = (state != EMPTY).
- EMPTY transitions:
  - accept: main <= in_data, go to ONE.
  - otherwise hold.
- ONE transitions:
  - accept & take: main <= in_data, stay ONE.
  - accept only: skid <= in_data, go to FULL.
  - take only: go to EMPTY.
  - neither: hold.
- FULL transitions:
  - take: main <= skid, go to ONE.
  - otherwise hold. No accept is possible in FULL because in_ready = 0.
- Channels are never reordered or mixed. All NCH channels of a beat always move together.
- Beats exit in strict arrival order. No beat is duplicated or dropped, except by flush or reset.
- in_valid while in_ready = 0 has no effect. Upstream holds its data.
- out_data content while out_valid = 0 is don't-care for consumers. The block must not alter main except on the transitions listed above.

## Timing
- Reset values (rst high at a clock edge):
  - state EMPTY, occupancy 0, in_ready 1, out_valid 0.
  - main and skid registers clear to 0, so out_data = 0.
- rst has priority over flush, accept and take. Any in-flight beats are lost.
- flush is high at an edge (rst low):
  - state goes to EMPTY, occupancy 0.
  - main and skid keep their contents.
  - A simultaneous accept is discarded.
  - A simultaneous take is still valid for downstream (it sampled out_data that cycle).
- Latency: a beat accepted at edge N in EMPTY or ONE-with-take appears on out_data with out_valid = 1 after edge N.
- Throughput: 1 beat/cycle while out_ready = 1 continuously.
- Stall response: out_ready low for one cycle in ONE with in_valid high fills skid (FULL). in_ready drops on the following cycle, never combinationally.
- Recovery: the first take in FULL moves skid to main. in_ready returns to 1 on the next cycle.
- occupancy is registered and always equals the entry count after each edge.
- No combinational path from in_valid/out_ready to in_ready/out_valid.

## Test plan
- Reset, with WIDTH=24 and NCH=2: assert rst 2 cycles with in_valid = 1 -> occupancy 0, out_valid 0, in_ready 1, out_data 0; nothing accepted.
- Streaming: out_ready = 1; send A/B pairs (0x800001/0xC00000), (0xFFFFFF/0x800000), (0x912345/0xABCDEF) back-to-back -> each pair appears on out_data exactly 1 cycle after acceptance, in order, with channel 0 = A; occupancy stays 1 during the stream.
- Stall and skid: stream continuous beats 1,2,3,4, drop out_ready for 3 cycles after beat 1 appears -> occupancy reaches 2 and in_ready goes 0 with no beat lost; on release, output order is 1,2,3,4 with no duplicates.
- Drain from FULL: hold in_valid = 0, raise out_ready -> two consecutive takes, occupancy 2->1->0, out_valid drops after the second take.
- Flush mid-stream: in FULL with beats 5,6 buffered, pulse flush together with in_valid (beat 7) -> next cycle occupancy 0, out_valid 0, in_ready 1; beat 7 never appears; the next accepted beat 8 is the next output.
- Randomised check: random in_valid/out_ready at 50% each for 10k cycles against a scoreboard queue -> exact in-order match, occupancy never exceeds 2, in_ready never 1 while FULL.
